pes_coin_acceptor: RTL and testbench

PES_COIN_ACCEPTOR -- requirements
Module: pes_coin_acceptor

---
 rtl/pes_coin_acceptor.sv | 148 ++++++++++++++
 tb/tb_pes_coin_acceptor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pes_coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces two coin sensors, screens jams and
// refusals, queues accepted coins in a 2-entry FIFO and issues them to the ticket FSM.
module pes_coin_acceptor #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       reject,
    output logic [1:0] fifo_cnt,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    // Sensor index 0 is the nickel, index 1 is the dime.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] lvl;
    logic [1:0] lvl_prev;
    logic [3:0] db_cnt [2];

    logic [1:0] rise;
    logic       jam;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       full;
    logic       refuse;

    // FIFO handshake: push is a valid that is only raised while ready (not full);
    // pop is taken by the FSM only while the FIFO is non-empty. Both may fire together.
    logic       push;
    logic       pop;
    logic [1:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] coin_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            lvl      <= '0;
            lvl_prev <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= {dime_raw, nickel_raw};
            sync2    <= sync1;
            lvl_prev <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != lvl[i]) begin
                    // The sample that would make the count reach DB_CYCLES flips the level.
                    if (db_cnt[i] == DB_LAST) begin
                        lvl[i]    <= ~lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 4'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        rise     = lvl & ~lvl_prev;
        // A rise is a jam if the other sensor is high, whether it rose now or earlier.
        jam      = (rise[0] & lvl[1]) | (rise[1] & lvl[0]);
        ev_valid = (|rise) & ~jam;
        ev_code  = rise[0] ? 2'b01 : 2'b10;
        full     = (cnt == 2'd2);
        push     = ev_valid & accept_en & ~full;
        refuse   = jam | (ev_valid & (~accept_en | full));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ev_code;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            coin   <= 2'b00;
            reject <= 1'b0;
        end else begin
            state  <= state_nxt;
            coin   <= coin_nxt;
            reject <= refuse;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cnt != 2'd0) state_nxt = DRIVE;
            DRIVE:   state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == IDLE) && (cnt != 2'd0);
        coin_nxt = pop ? mem[rd_ptr] : 2'b00;
    end

    assign fifo_cnt  = cnt;
    assign fsm_state = state;

    a_coin_legal : assert property (@(posedge clk) disable iff (rst) coin != 2'b11);
    a_cnt_bound  : assert property (@(posedge clk) disable iff (rst) cnt <= 2'd2);

endmodule

// File: tb/tb_pes_coin_acceptor.sv
// Bench for pes_coin_acceptor: two instances (DB_CYCLES 4 and 2) run in lockstep against a
// cycle model built from sensor-run counts, a coin queue and an issue cooldown.
module tb_pes_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       nickel_raw;
  logic       dime_raw;
  logic       accept_en;
  logic [1:0] coin4, fifo4, st4;
  logic [1:0] coin2, fifo2, st2;
  logic       rej4, rej2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pes_coin_acceptor #(.DB_CYCLES(4)) u_db4 (
    .clk(clk), .rst(rst), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
    .accept_en(accept_en), .coin(coin4), .reject(rej4), .fifo_cnt(fifo4), .fsm_state(st4)
  );

  pes_coin_acceptor #(.DB_CYCLES(2)) u_db2 (
    .clk(clk), .rst(rst), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
    .accept_en(accept_en), .coin(coin2), .reject(rej2), .fifo_cnt(fifo2), .fsm_state(st2)
  );

  // reference model state, index k: 0 -> DB_CYCLES=4, 1 -> DB_CYCLES=2
  int         m_db [2];
  bit         m_s1 [2][2];
  bit         m_s2 [2][2];
  bit         m_lvl [2][2];
  bit         m_prev [2][2];
  int         m_run [2][2];
  logic [1:0] m_q [2][$];
  int         m_cool [2];
  logic [1:0] e_coin [2];
  logic       e_rej [2];

  int n_rej [2];
  int n_coin [2];
  int max_cnt [2];
  int first_edge [2];
  int edge_n;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int  pre;
    bit  rn;
    bit  rd;
    bit  raw [2];
    raw[0] = nickel_raw;
    raw[1] = dime_raw;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[k][i] = 0; m_s2[k][i] = 0; m_lvl[k][i] = 0; m_prev[k][i] = 0; m_run[k][i] = 0;
      end
      m_q[k].delete();
      m_cool[k] = 0;
      e_coin[k] = 2'b00;
      e_rej[k] = 1'b0;
      return;
    end
    // issue side: one coin, then two empty cycles before the next may go out
    pre = m_q[k].size();
    if (m_cool[k] == 0 && pre > 0) begin
      e_coin[k] = m_q[k].pop_front();
      m_cool[k] = 2;
    end else begin
      e_coin[k] = 2'b00;
      if (m_cool[k] > 0) m_cool[k]--;
    end
    // coin events from debounced rising edges
    rn = m_lvl[k][0] && !m_prev[k][0];
    rd = m_lvl[k][1] && !m_prev[k][1];
    e_rej[k] = 1'b0;
    if (rn || rd) begin
      if ((rn && m_lvl[k][1]) || (rd && m_lvl[k][0])) e_rej[k] = 1'b1;
      else if (!accept_en || pre == 2) e_rej[k] = 1'b1;
      else m_q[k].push_back(rn ? 2'b01 : 2'b10);
    end
    // a level flips after m_db consecutive disagreeing synchronized samples
    for (int i = 0; i < 2; i++) begin
      m_prev[k][i] = m_lvl[k][i];
      if (m_s2[k][i] != m_lvl[k][i]) begin
        m_run[k][i]++;
        if (m_run[k][i] == m_db[k]) begin
          m_lvl[k][i] = !m_lvl[k][i];
          m_run[k][i] = 0;
        end
      end else begin
        m_run[k][i] = 0;
      end
      m_s2[k][i] = m_s1[k][i];
      m_s1[k][i] = raw[i];
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      n_rej[k] = 0; n_coin[k] = 0; max_cnt[k] = 0; first_edge[k] = 0;
    end
    edge_n = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    edge_n++;
    chk("coin_db4", 8'(coin4), 8'(e_coin[0]));
    chk("reject_db4", 8'(rej4), 8'(e_rej[0]));
    chk("fifo_cnt_db4", 8'(fifo4), 8'(m_q[0].size()));
    chk("coin_db2", 8'(coin2), 8'(e_coin[1]));
    chk("reject_db2", 8'(rej2), 8'(e_rej[1]));
    chk("fifo_cnt_db2", 8'(fifo2), 8'(m_q[1].size()));
    if (rej4) n_rej[0]++;
    if (rej2) n_rej[1]++;
    if (coin4 != 2'b00) begin
      n_coin[0]++;
      if (first_edge[0] == 0) first_edge[0] = edge_n;
    end
    if (coin2 != 2'b00) begin
      n_coin[1]++;
      if (first_edge[1] == 0) first_edge[1] = edge_n;
    end
    if (int'(fifo4) > max_cnt[0]) max_cnt[0] = int'(fifo4);
    if (int'(fifo2) > max_cnt[1]) max_cnt[1] = int'(fifo2);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    nickel_raw = 1'b0;
    dime_raw = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int len;
    m_db[0] = 4;
    m_db[1] = 2;
    rst = 1'b1;
    nickel_raw = 1'b0;
    dime_raw = 1'b0;
    accept_en = 1'b1;
    clear_stats();

    // reset state
    repeat (3) tick();
    chk("reset_coin", 8'(coin4), 8'd0);
    chk("reset_reject", 8'(rej4), 8'd0);
    chk("reset_fifo_cnt", 8'(fifo4), 8'd0);
    rst = 1'b0;
    idle(2);

    // single nickel, 10 cycles high: coin 01 for one cycle after DB+4 edges
    clear_stats();
    nickel_raw = 1'b1;
    repeat (10) tick();
    nickel_raw = 1'b0;
    repeat (12) tick();
    chk("nickel_latency_db4", 8'(first_edge[0]), 8'd8);
    chk("nickel_latency_db2", 8'(first_edge[1]), 8'd6);
    chk("nickel_coin_cycles", 8'(n_coin[0]), 8'd1);
    chk("nickel_no_reject", 8'(n_rej[0]), 8'd0);
    chk("nickel_fifo_peak", 8'(max_cnt[0]), 8'd1);

    // dime chattering every cycle never debounces
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      dime_raw = i[0];
      tick();
    end
    idle(12);
    chk("chatter_no_coin_db4", 8'(n_coin[0]), 8'd0);
    chk("chatter_no_coin_db2", 8'(n_coin[1]), 8'd0);

    // simultaneous nickel and dime: one jam reject, nothing issued
    clear_stats();
    nickel_raw = 1'b1;
    dime_raw = 1'b1;
    repeat (10) tick();
    idle(14);
    chk("jam_reject_db4", 8'(n_rej[0]), 8'd1);
    chk("jam_reject_db2", 8'(n_rej[1]), 8'd1);
    chk("jam_no_coin_db4", 8'(n_coin[0]), 8'd0);
    chk("jam_no_coin_db2", 8'(n_coin[1]), 8'd0);

    // fast alternating coins fill the DB=2 FIFO and force full rejects
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      nickel_raw = 1'b1; dime_raw = 1'b0;
      repeat (2) tick();
      nickel_raw = 1'b0; dime_raw = 1'b1;
      repeat (2) tick();
    end
    idle(24);
    chk("fill_fifo_peak_db2", 8'(max_cnt[1]), 8'd2);
    chk("fill_full_reject_db2", 8'(n_rej[1] > 0), 8'd1);
    chk("fill_short_pulses_db4", 8'(n_coin[0]), 8'd0);

    // coins refused while accept_en is low
    clear_stats();
    accept_en = 1'b0;
    nickel_raw = 1'b1;
    repeat (10) tick();
    idle(12);
    accept_en = 1'b1;
    chk("disabled_reject", 8'(n_rej[0]), 8'd1);
    chk("disabled_fifo_peak", 8'(max_cnt[0]), 8'd0);
    chk("disabled_no_coin", 8'(n_coin[0]), 8'd0);

    // reset while driving a coin, sensor held high across reset release
    nickel_raw = 1'b1;
    for (int i = 0; i < 30 && coin4 == 2'b00; i++) tick();
    chk("wait_drive", 8'(coin4 != 2'b00), 8'd1);
    rst = 1'b1;
    tick();
    chk("rst_drive_coin", 8'(coin4), 8'd0);
    chk("rst_drive_fifo_cnt", 8'(fifo4), 8'd0);
    rst = 1'b0;
    clear_stats();
    repeat (12) tick();
    chk("held_across_reset_latency", 8'(first_edge[0]), 8'd8);
    idle(16);

    // randomized segments
    for (int s = 0; s < 300; s++) begin
      nickel_raw = 1'($urandom_range(0, 1));
      dime_raw = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 2) == 0) nickel_raw = 1'b0;
      accept_en = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 49) == 0);
      len = $urandom_range(1, 10);
      repeat (len) begin
        tick();
        rst = 1'b0;
      end
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
